irq_gen: RTL and testbench

- Interrupt source controller that drives the CPU core's 32-bit `irq` vector and consumes its `eoi` vector, i.e. the device-side end of the IRQ/EOI interface.
- Aggregates 32 peripheral event lines, each with per-line enable and edge/level configuration.
- Provides a built-in countdown timer on line 0 and keeps lines reserved for core-internal causes (ebreak, bus error) permanently low.
- Sits between peripherals and the core, and is configured through a small word-addressed register port.

---
 rtl/irq_gen_pkg.sv | 24 ++
 rtl/irq_gen_line.sv | 59 +++++
 rtl/irq_gen.sv | 126 ++++++++++++
 tb/tb_irq_gen.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/irq_gen_pkg.sv
// Shared types and constants for the irq_gen interrupt source controller.
package irq_gen_pkg;

  localparam int NUM_LINES = 32;

  // Lines 1 (ebreak) and 2 (bus error) are raised inside the core itself.
  localparam logic [NUM_LINES-1:0] DEFAULT_RESERVED_MASK = 32'h0000_0006;

  // Word addresses of the configuration registers.
  localparam logic [1:0] CFG_EN     = 2'd0;
  localparam logic [1:0] CFG_EDGE   = 2'd1;
  localparam logic [1:0] CFG_TIMER  = 2'd2;
  localparam logic [1:0] CFG_RELOAD = 2'd3;

  // Per-line handshake state. SERV_RE is "in service, and another event
  // arrived meanwhile", so the event is replayed once the handler finishes.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PEND    = 2'b01,
    SERV    = 2'b10,
    SERV_RE = 2'b11
  } line_state_e;

endpackage : irq_gen_pkg

// File: rtl/irq_gen_line.sv
// One interrupt line: request/service handshake with the core's eoi bit.
module irq_gen_line
  import irq_gen_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic trig,
  input  logic en,
  input  logic eoi_rise,
  input  logic eoi_fall,
  output logic req
);

  line_state_e state_q;
  line_state_e state_d;

  // Next-state logic; a disabled line collapses to IDLE from any state.
  always_comb begin
    // NOTE: state_d gets a default before any branch so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d = state_q;
    if (!en) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (trig) state_d = PEND;
        end
        PEND: begin
          // A new event coinciding with the acknowledge must not be lost.
          if (eoi_rise) state_d = trig ? SERV_RE : SERV;
        end
        SERV: begin
          if (eoi_fall)  state_d = trig ? PEND : IDLE;
          else if (trig) state_d = SERV_RE;
        end
        SERV_RE: begin
          if (eoi_fall) state_d = PEND;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State register; the request is registered from the next state so it
  // drops in the same update that enters service.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q <= IDLE;
      req     <= 1'b0;
    end else begin
      state_q <= state_d;
      req     <= (state_d == PEND);
    end
  end

endmodule : irq_gen_line

// File: rtl/irq_gen.sv
// Interrupt source controller: 32 configurable event lines plus a countdown
// timer on TIMER_LINE, driving the core's irq vector and tracking its eoi.
module irq_gen
  import irq_gen_pkg::*;
#(
  parameter logic [NUM_LINES-1:0] RESERVED_MASK = DEFAULT_RESERVED_MASK,
  parameter int                   TIMER_LINE    = 0,
  parameter int                   TIMER_W       = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_LINES-1:0] src_event,
  input  logic [NUM_LINES-1:0] eoi,
  output logic [NUM_LINES-1:0] irq,
  input  logic                 cfg_we,
  input  logic [1:0]           cfg_addr,
  input  logic [31:0]          cfg_wdata,
  output logic [31:0]          cfg_rdata,
  output logic [NUM_LINES-1:0] pending
);

  localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);
  localparam logic [TIMER_W-1:0] TIMER_ZERO = '0;

  logic [NUM_LINES-1:0] en_q;
  logic [NUM_LINES-1:0] edge_q;
  logic [TIMER_W-1:0]   timer_q;
  logic [TIMER_W-1:0]   reload_q;
  logic [NUM_LINES-1:0] src_q;
  logic [NUM_LINES-1:0] eoi_q;

  logic                 wr_en;
  logic                 wr_edge;
  logic                 wr_timer;
  logic                 wr_reload;
  logic [NUM_LINES-1:0] en_d;
  logic [TIMER_W-1:0]   timer_d;
  logic                 expire;
  logic [NUM_LINES-1:0] eoi_rise;
  logic [NUM_LINES-1:0] eoi_fall;
  logic [NUM_LINES-1:0] trig;
  logic [NUM_LINES-1:0] req;

  // Write decode; the line FSMs see a new EN value at the edge that stores
  // it, so disabling a line clears it on that same edge.
  always_comb begin
    wr_en     = cfg_we && (cfg_addr == CFG_EN);
    wr_edge   = cfg_we && (cfg_addr == CFG_EDGE);
    wr_timer  = cfg_we && (cfg_addr == CFG_TIMER);
    wr_reload = cfg_we && (cfg_addr == CFG_RELOAD);
    en_d      = wr_en ? (cfg_wdata & ~RESERVED_MASK) : en_q;
  end

  // Timer next value; a software write in the 1->0 cycle pre-empts expiry.
  always_comb begin
    expire  = (timer_q == TIMER_ONE) && !wr_timer;
    timer_d = timer_q;
    if (wr_timer) begin
      timer_d = cfg_wdata[TIMER_W-1:0];
    end else if (expire) begin
      timer_d = reload_q;
    end else if (timer_q != TIMER_ZERO) begin
      timer_d = timer_q - TIMER_ONE;
    end
  end

  // Per-line trigger selection and eoi edge detection.
  always_comb begin
    eoi_rise = eoi & ~eoi_q;
    eoi_fall = ~eoi & eoi_q;
    // Level lines are masked while the handler is active and for one cycle
    // after it ends, so a still-asserted level re-requests from IDLE rather
    // than being recorded as a fresh event during service.
    trig = (edge_q & src_event & ~src_q) |
           (~edge_q & src_event & ~(eoi | eoi_q));
    trig[TIMER_LINE] = expire;
  end

  // Configuration registers, timer and input sampling registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q     <= '0;
      edge_q   <= '0;
      timer_q  <= '0;
      reload_q <= '0;
      src_q    <= '0;
      eoi_q    <= '0;
    end else begin
      en_q    <= en_d;
      timer_q <= timer_d;
      src_q   <= src_event;
      eoi_q   <= eoi;
      if (wr_edge)   edge_q   <= cfg_wdata;
      if (wr_reload) reload_q <= cfg_wdata[TIMER_W-1:0];
    end
  end

  // Combinational readback; TIMER returns the live count.
  always_comb begin
    cfg_rdata = '0;
    unique case (cfg_addr)
      CFG_EN:     cfg_rdata = en_q;
      CFG_EDGE:   cfg_rdata = edge_q;
      CFG_TIMER:  cfg_rdata = 32'(timer_q);
      CFG_RELOAD: cfg_rdata = 32'(reload_q);
      default:    cfg_rdata = '0;
    endcase
  end

  for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
    irq_gen_line u_line (
      .clk      (clk),
      .reset    (reset),
      .trig     (trig[i]),
      .en       (en_d[i]),
      .eoi_rise (eoi_rise[i]),
      .eoi_fall (eoi_fall[i]),
      .req      (req[i])
    );
  end

  // Reserved lines can never reach the core.
  assign irq     = req & ~RESERVED_MASK;
  assign pending = irq;

endmodule : irq_gen

// File: tb/tb_irq_gen.sv
// Directed bench for irq_gen: stimulus schedules expected values into a
// scoreboard; a negedge monitor compares them when their cycle comes due.
module tb_irq_gen;
  import irq_gen_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] src_event;
  logic [31:0] eoi;
  logic [31:0] irq;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  logic [31:0] pending;

  irq_gen dut (
    .clk       (clk),
    .reset     (reset),
    .src_event (src_event),
    .eoi       (eoi),
    .irq       (irq),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum logic {CK_IRQ, CK_RDATA} chk_kind_e;
  typedef struct {
    chk_kind_e   kind;
    int          due;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Expect a value 'lat' clock edges after the current point in the stimulus.
  task automatic sched(chk_kind_e k, int lat, logic [31:0] v, string nm);
    chk_t c;
    c.kind = k;
    c.due  = cyc + lat;
    c.exp  = v;
    c.name = nm;
    sb.push_back(c);
  endtask

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: compare every scoreboard entry that falls due this cycle.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due < cyc) begin
        n_vec++;
        n_bad++;
        $display("FAIL %s: check missed its cycle %0d", sb[i].name, sb[i].due);
        sb.delete(i);
      end else if (sb[i].due == cyc) begin
        if (sb[i].kind == CK_IRQ) begin
          cmp(sb[i].name, irq, sb[i].exp);
          cmp({sb[i].name, "_pending"}, pending, sb[i].exp);
        end else begin
          cmp(sb[i].name, cfg_rdata, sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  task automatic step(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(logic [1:0] a, logic [31:0] d);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    step(1);
    cfg_we    = 1'b0;
    cfg_wdata = '0;
  endtask

  initial begin
    reset     = 1'b1;
    src_event = '0;
    eoi       = '0;
    cfg_we    = 1'b0;
    cfg_addr  = CFG_EN;
    cfg_wdata = '0;
    step(2);
    sched(CK_IRQ,   0, 32'h0, "reset_irq");
    sched(CK_RDATA, 0, 32'h0, "reset_en");
    step(1);
    reset = 1'b0;
    step(1);

    // Edge line 4: request, plain service back to IDLE.
    cfg_write(CFG_EN, 32'h10);
    cfg_write(CFG_EDGE, 32'h10);
    src_event = 32'h10; sched(CK_IRQ, 1, 32'h10, "edge_req"); step(1);
    src_event = '0;
    sched(CK_IRQ, 1, 32'h10, "edge_hold");
    sched(CK_IRQ, 2, 32'h10, "edge_hold2"); step(2);
    eoi = 32'h10; sched(CK_IRQ, 1, 32'h0, "edge_ack"); step(1);
    eoi = '0;
    sched(CK_IRQ, 1, 32'h0, "edge_idle");
    sched(CK_IRQ, 3, 32'h0, "edge_idle2"); step(3);

    // Event during service is remembered and replayed after eoi falls.
    src_event = 32'h10; sched(CK_IRQ, 1, 32'h10, "svc_req"); step(1);
    src_event = '0;
    eoi = 32'h10; sched(CK_IRQ, 1, 32'h0, "svc_ack"); step(1);
    src_event = 32'h10; sched(CK_IRQ, 1, 32'h0, "svc_event_hidden"); step(1);
    src_event = '0; sched(CK_IRQ, 1, 32'h0, "svc_still_hidden"); step(1);
    eoi = '0; sched(CK_IRQ, 1, 32'h10, "svc_replay"); step(1);
    eoi = 32'h10; sched(CK_IRQ, 1, 32'h0, "svc_ack2"); step(1);
    eoi = '0; sched(CK_IRQ, 1, 32'h0, "svc_idle"); step(1);

    // Event coinciding with the acknowledge is retained.
    src_event = 32'h10; sched(CK_IRQ, 1, 32'h10, "sim_req"); step(1);
    src_event = '0; step(1);
    src_event = 32'h10; eoi = 32'h10; sched(CK_IRQ, 1, 32'h0, "sim_ack"); step(1);
    src_event = '0; step(1);
    eoi = '0; sched(CK_IRQ, 1, 32'h10, "sim_replay"); step(1);
    eoi = 32'h10; step(1);
    eoi = '0; sched(CK_IRQ, 1, 32'h0, "sim_idle"); step(2);

    // Level line 8: held level re-requests from IDLE after the eoi fall.
    cfg_write(CFG_EN, 32'h100);
    cfg_write(CFG_EDGE, 32'h0);
    src_event = 32'h100; sched(CK_IRQ, 1, 32'h100, "lvl_req"); step(1);
    eoi = 32'h100;
    sched(CK_IRQ, 1, 32'h0, "lvl_ack");
    sched(CK_IRQ, 2, 32'h0, "lvl_serv"); step(2);
    eoi = '0;
    sched(CK_IRQ, 1, 32'h0,   "lvl_fall_idle");
    sched(CK_IRQ, 2, 32'h100, "lvl_rearm"); step(2);
    eoi = 32'h100; sched(CK_IRQ, 1, 32'h0, "lvl_ack2"); step(1);
    src_event = '0; step(1);
    eoi = '0;
    sched(CK_IRQ, 1, 32'h0, "lvl_no_rearm1");
    sched(CK_IRQ, 2, 32'h0, "lvl_no_rearm2");
    sched(CK_IRQ, 3, 32'h0, "lvl_no_rearm3"); step(3);

    // Timer on line 0: first expiry 3 cycles after load, then period 5.
    cfg_write(CFG_EN, 32'h1);
    cfg_write(CFG_RELOAD, 32'd5);
    cfg_write(CFG_TIMER, 32'd3);
    sched(CK_RDATA, 0, 32'd3, "tmr_load");
    sched(CK_IRQ,   2, 32'h0, "tmr_early");
    sched(CK_IRQ,   3, 32'h1, "tmr_fire"); step(3);
    sched(CK_RDATA, 0, 32'd5, "tmr_reload");
    eoi = 32'h1; sched(CK_IRQ, 1, 32'h0, "tmr_ack"); step(1);
    eoi = '0;
    sched(CK_IRQ, 1, 32'h0, "tmr_idle");
    sched(CK_IRQ, 3, 32'h0, "tmr_period_early");
    sched(CK_IRQ, 4, 32'h1, "tmr_period"); step(4);
    eoi = 32'h1; step(1);
    eoi = '0; step(1);
    step(2);
    sched(CK_RDATA, 0, 32'd1, "tmr_one");
    cfg_write(CFG_TIMER, 32'd7);
    sched(CK_IRQ,   0, 32'h0, "tmr_suppress");
    sched(CK_RDATA, 0, 32'd7, "tmr_write_wins");
    sched(CK_RDATA, 1, 32'd6, "tmr_count"); step(1);
    cfg_write(CFG_TIMER, 32'd0);
    src_event = 32'h1;
    sched(CK_RDATA, 0, 32'd0, "tmr_stop");
    sched(CK_IRQ,   8, 32'h0, "tmr_stopped");
    sched(CK_RDATA, 8, 32'd0, "tmr_stay_zero"); step(9);
    src_event = '0;

    // Reserved lines never assert; disabling clears a pending line.
    cfg_write(CFG_EN, 32'hFFFF_FFFF);
    sched(CK_RDATA, 0, 32'hFFFF_FFF9, "rsv_en_rb");
    src_event = 32'hA000_0116;
    sched(CK_IRQ, 1, 32'hA000_0110, "rsv_multi");
    sched(CK_IRQ, 2, 32'hA000_0110, "rsv_multi2"); step(2);
    src_event = '0;
    cfg_write(CFG_EN, 32'h0);
    sched(CK_IRQ,   0, 32'h0, "dis_irq");
    sched(CK_RDATA, 0, 32'h0, "dis_en_rb"); step(1);

    // Asynchronous reset with a line pending and the timer running.
    cfg_write(CFG_EN, 32'h10);
    cfg_write(CFG_EDGE, 32'h10);
    cfg_write(CFG_RELOAD, 32'd9);
    cfg_write(CFG_TIMER, 32'd20);
    src_event = 32'h10; sched(CK_IRQ, 1, 32'h10, "rst_pre"); step(1);
    src_event = '0; step(1);
    sched(CK_RDATA, 0, 32'd18, "rst_timer_run");
    step(1);
    reset = 1'b1;
    sched(CK_IRQ,   0, 32'h0, "rst_irq");
    sched(CK_RDATA, 0, 32'h0, "rst_timer");
    step(2);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cfg_addr = 2'(k);
      sched(CK_RDATA, 0, 32'h0, $sformatf("rst_cfg%0d", k));
      step(1);
    end

    step(2);
    for (int k = 0; k < 20 && sb.size() > 0; k++) step(1);
    if (sb.size() > 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d checks still queued", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_irq_gen
